// File: rtl/variable_step_controller.sv
// variable_step_controller
// Holds the current value of every boolean, integer and discrete variable of
// the sampler. Per MCMC step it pulses the chooser, captures the chosen
// variable, presents its value to the proposal stage over valid/ready and
// writes the committed value back when the move is accepted.
//
// Optional feature: define VARIABLE_STEP_COUNTER_EN to build the 32-bit
// accepted-step counter on out_accept_count; otherwise the port reads 0.
module variable_step_controller #(
  parameter int NUM_BOOL    = 2,
  parameter int NUM_INT     = 3,
  parameter int NUM_DISC    = 2,
  parameter int VALUE_WIDTH = 16,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic                   in_start,
  output logic                   out_chooser_enable,
  input  logic [1:0]             in_choosen_type,
  input  logic [INDEX_WIDTH-1:0] in_choosen_index,
  output logic                   out_valid,
  input  logic                   in_ready,
  output logic [1:0]             out_type,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic [VALUE_WIDTH-1:0] out_value,
  input  logic                   in_commit_valid,
  input  logic                   in_commit_accept,
  input  logic [VALUE_WIDTH-1:0] in_commit_value,
  input  logic                   in_load_valid,
  input  logic [1:0]             in_load_type,
  input  logic [INDEX_WIDTH-1:0] in_load_index,
  input  logic [VALUE_WIDTH-1:0] in_load_value,
  output logic                   out_busy,
  output logic                   out_error,
  output logic [31:0]            out_accept_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHOOSE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_COMMIT  = 3'd4;

  localparam logic [1:0] T_BOOL = 2'd0;
  localparam logic [1:0] T_INT  = 2'd1;
  localparam logic [1:0] T_DISC = 2'd2;

  localparam logic [31:0] BOOL_LIM = 32'(NUM_BOOL);
  localparam logic [31:0] INT_LIM  = 32'(NUM_INT);
  localparam logic [31:0] DISC_LIM = 32'(NUM_DISC);

  logic [2:0] state;
  logic [2:0] next_state;

  // Variable storage; integers are two's complement, booleans live in bit 0.
  logic        [VALUE_WIDTH-1:0] bool_mem [NUM_BOOL];
  logic signed [VALUE_WIDTH-1:0] int_mem  [NUM_INT];
  logic        [VALUE_WIDTH-1:0] disc_mem [NUM_DISC];

  // Captured variable (stage 1) and presentation valid (stage 2).
  logic [1:0]             cap_type_p1;
  logic [INDEX_WIDTH-1:0] cap_index_p1;
  logic [VALUE_WIDTH-1:0] cap_value_p1;
  logic                   vld_p2;
  logic                   err_p1;

  logic [VALUE_WIDTH-1:0] rd_value;
  logic                   choice_ok;
  logic                   wr_en;
  logic [1:0]             wr_type;
  logic [INDEX_WIDTH-1:0] wr_index;
  logic [VALUE_WIDTH-1:0] wr_value;
  logic                   load_err;

  // True when (t, idx) names an existing variable; type 3 never does.
  function automatic logic target_ok(input logic [1:0] t,
                                     input logic [INDEX_WIDTH-1:0] idx);
    logic ok;
    ok = 1'b0;
    case (t)
      T_BOOL:  ok = (32'(idx) < BOOL_LIM);
      T_INT:   ok = (32'(idx) < INT_LIM);
      T_DISC:  ok = (32'(idx) < DISC_LIM);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Booleans keep only bit 0; integer and discrete values pass unchanged.
  function automatic logic [VALUE_WIDTH-1:0] fit_value(input logic [1:0] t,
                                                       input logic [VALUE_WIDTH-1:0] v);
    logic [VALUE_WIDTH-1:0] r;
    if (t == T_BOOL) begin
      r = {{(VALUE_WIDTH-1){1'b0}}, v[0]};
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign choice_ok = target_ok(in_choosen_type, in_choosen_index);

  // Read mux: value of the variable currently named by the chooser.
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NUM_BOOL; i++) begin
      if (in_choosen_type == T_BOOL && 32'(in_choosen_index) == 32'(i)) rd_value = bool_mem[i];
    end
    for (int i = 0; i < NUM_INT; i++) begin
      if (in_choosen_type == T_INT && 32'(in_choosen_index) == 32'(i)) rd_value = int_mem[i];
    end
    for (int i = 0; i < NUM_DISC; i++) begin
      if (in_choosen_type == T_DISC && 32'(in_choosen_index) == 32'(i)) rd_value = disc_mem[i];
    end
  end

  // Single write port: initial-assignment loads in IDLE, accepted commits in COMMIT.
  always_comb begin
    wr_en    = 1'b0;
    wr_type  = cap_type_p1;
    wr_index = cap_index_p1;
    wr_value = in_commit_value;
    load_err = 1'b0;
    if (state == S_IDLE && in_load_valid) begin
      if (target_ok(in_load_type, in_load_index)) begin
        wr_en    = 1'b1;
        wr_type  = in_load_type;
        wr_index = in_load_index;
        wr_value = in_load_value;
      end else begin
        load_err = 1'b1;
      end
    end else if (state == S_COMMIT && in_commit_valid && in_commit_accept) begin
      wr_en = 1'b1;
    end
  end

  // Storage update; reset clears every variable.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      for (int i = 0; i < NUM_BOOL; i++) bool_mem[i] <= '0;
      for (int i = 0; i < NUM_INT; i++)  int_mem[i]  <= '0;
      for (int i = 0; i < NUM_DISC; i++) disc_mem[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BOOL; i++) begin
        if (wr_type == T_BOOL && 32'(wr_index) == 32'(i)) bool_mem[i] <= fit_value(wr_type, wr_value);
      end
      for (int i = 0; i < NUM_INT; i++) begin
        if (wr_type == T_INT && 32'(wr_index) == 32'(i)) int_mem[i] <= $signed(wr_value);
      end
      for (int i = 0; i < NUM_DISC; i++) begin
        if (wr_type == T_DISC && 32'(wr_index) == 32'(i)) disc_mem[i] <= wr_value;
      end
    end
  end

  // Step sequencing; a load in IDLE takes priority over start.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (!in_load_valid && in_start) next_state = S_CHOOSE;
      S_CHOOSE:  next_state = S_CAPTURE;
      S_CAPTURE: next_state = choice_ok ? S_PRESENT : S_CHOOSE;
      S_PRESENT: if (vld_p2 && in_ready) next_state = S_COMMIT;
      S_COMMIT:  if (in_commit_valid) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // State register; reset aborts any step in flight.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) state <= S_IDLE;
    else          state <= next_state;
  end

  // Stage 1: capture the chooser output and the variable's current value.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      cap_type_p1  <= '0;
      cap_index_p1 <= '0;
      cap_value_p1 <= '0;
    end else if (state == S_CAPTURE) begin
      cap_type_p1  <= in_choosen_type;
      cap_index_p1 <= in_choosen_index;
      cap_value_p1 <= rd_value;
    end
  end

  // Stage 2: presentation valid rises one cycle into PRESENT and clears on the handshake.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) vld_p2 <= 1'b0;
    else          vld_p2 <= (state == S_PRESENT) && !(vld_p2 && in_ready);
  end

  // One-cycle error pulse for a bad load target or a bad chooser output.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) err_p1 <= 1'b0;
    else          err_p1 <= load_err || (state == S_CAPTURE && !choice_ok);
  end

`ifdef VARIABLE_STEP_COUNTER_EN
  logic [31:0] accept_cnt;

  // Accepted-step counter, wraps naturally at 2^32.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) accept_cnt <= '0;
    else if (state == S_COMMIT && in_commit_valid && in_commit_accept) accept_cnt <= accept_cnt + 32'd1;
  end

  assign out_accept_count = accept_cnt;
`else
  assign out_accept_count = '0;
`endif

  assign out_chooser_enable = (state == S_CHOOSE);
  assign out_valid          = vld_p2;
  assign out_type           = cap_type_p1;
  assign out_index          = cap_index_p1;
  assign out_value          = cap_value_p1;
  assign out_busy           = (state != S_IDLE);
  assign out_error          = err_p1;

endmodule

// File: tb/tb_variable_step_controller.sv
// Randomized scoreboard bench for variable_step_controller.
module tb_variable_step_controller;

  localparam int NB = 2;
  localparam int NI = 3;
  localparam int ND = 2;
  localparam int VW = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          in_reset;
  logic          in_start;
  logic          out_chooser_enable;
  logic [1:0]    in_choosen_type;
  logic [IW-1:0] in_choosen_index;
  logic          out_valid;
  logic          in_ready;
  logic [1:0]    out_type;
  logic [IW-1:0] out_index;
  logic [VW-1:0] out_value;
  logic          in_commit_valid;
  logic          in_commit_accept;
  logic [VW-1:0] in_commit_value;
  logic          in_load_valid;
  logic [1:0]    in_load_type;
  logic [IW-1:0] in_load_index;
  logic [VW-1:0] in_load_value;
  logic          out_busy;
  logic          out_error;
  logic [31:0]   out_accept_count;

  always #5 clk = ~clk;

  variable_step_controller #(
    .NUM_BOOL(NB), .NUM_INT(NI), .NUM_DISC(ND), .VALUE_WIDTH(VW), .INDEX_WIDTH(IW)
  ) dut (
    .in_clock(clk), .in_reset(in_reset), .in_start(in_start),
    .out_chooser_enable(out_chooser_enable),
    .in_choosen_type(in_choosen_type), .in_choosen_index(in_choosen_index),
    .out_valid(out_valid), .in_ready(in_ready),
    .out_type(out_type), .out_index(out_index), .out_value(out_value),
    .in_commit_valid(in_commit_valid), .in_commit_accept(in_commit_accept),
    .in_commit_value(in_commit_value),
    .in_load_valid(in_load_valid), .in_load_type(in_load_type),
    .in_load_index(in_load_index), .in_load_value(in_load_value),
    .out_busy(out_busy), .out_error(out_error), .out_accept_count(out_accept_count)
  );

  typedef struct packed { logic [1:0] t; logic [7:0] i; logic [15:0] v; } pres_t;
  typedef struct packed { logic [1:0] t; logic [7:0] i; } ch_t;

  pres_t sb[$];
  ch_t   chq[$];

  // Reference model: plain arrays of current values.
  logic [15:0] m_bool [NB];
  logic [15:0] m_int  [NI];
  logic [15:0] m_disc [ND];
  int unsigned m_count = 0;

  int total = 0;
  int bad = 0;
  int exp_err = 0;
  int seen_err = 0;
  int enables = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit tgt_ok(input int t, input int i);
    if (t == 0) return i < NB;
    if (t == 1) return i < NI;
    if (t == 2) return i < ND;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_read(input int t, input int i);
    if (t == 0) return m_bool[i];
    if (t == 1) return m_int[i];
    return m_disc[i];
  endfunction

  task automatic model_write(input int t, input int i, input logic [15:0] v);
    if (t == 0) m_bool[i] = {15'd0, v[0]};
    else if (t == 1) m_int[i] = v;
    else m_disc[i] = v;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NB; k++) m_bool[k] = '0;
    for (int k = 0; k < NI; k++) m_int[k] = '0;
    for (int k = 0; k < ND; k++) m_disc[k] = '0;
    m_count = 0;
  endtask

  function automatic logic [31:0] exp_count();
`ifdef VARIABLE_STEP_COUNTER_EN
    return m_count;
`else
    return 32'd0;
`endif
  endfunction

  function automatic ch_t bad_choice();
    ch_t c;
    case ($urandom_range(0, 3))
      0: begin c.t = 2'd3; c.i = 8'($urandom_range(0, 255)); end
      1: begin c.t = 2'd0; c.i = 8'($urandom_range(NB, 255)); end
      2: begin c.t = 2'd1; c.i = 8'($urandom_range(NI, 255)); end
      default: begin c.t = 2'd2; c.i = 8'($urandom_range(ND, 255)); end
    endcase
    return c;
  endfunction

  // Chooser stand-in: on each enable cycle, drive the next queued choice.
  initial begin
    ch_t c;
    forever begin
      @(negedge clk);
      if (out_chooser_enable === 1'b1) begin
        enables++;
        if (chq.size() > 0) begin
          c = chq.pop_front();
          in_choosen_type  = c.t;
          in_choosen_index = c.i;
        end
      end
    end
  end

  // Error pulse counter.
  initial forever begin
    @(negedge clk);
    if (out_error === 1'b1) seen_err++;
  end

  // Scoreboard monitor: compare every handshaken presentation.
  initial begin
    pres_t p;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && in_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_present", 64'(out_valid), 64'(0));
        end else begin
          p = sb.pop_front();
          check("pres_type", 64'(out_type), 64'(p.t));
          check("pres_index", 64'(out_index), 64'(p.i));
          check("pres_value", 64'(out_value), 64'(p.v));
        end
      end
    end
  end

  task automatic do_load(input logic [1:0] t, input logic [7:0] i, input logic [15:0] v);
    @(posedge clk); #1;
    in_load_valid = 1'b1; in_load_type = t; in_load_index = i; in_load_value = v;
    @(posedge clk); #1;
    in_load_valid = 1'b0;
    if (tgt_ok(t, i)) model_write(t, i, v);
    else exp_err++;
  endtask

  task automatic run_step(input int pre_bad, input int rnd_bad, input logic [1:0] gt,
                          input logic [7:0] gi, input int ready_wait, input bit acc,
                          input logic [15:0] cv, input int cdelay);
    pres_t p;
    ch_t   c;
    int    e0, cyc, nb;
    nb = pre_bad + rnd_bad;
    for (int b = 0; b < rnd_bad; b++) chq.push_back(bad_choice());
    c.t = gt; c.i = gi;
    chq.push_back(c);
    p.t = gt; p.i = gi; p.v = model_read(gt, gi);
    sb.push_back(p);
    exp_err += nb;
    e0 = enables;
    @(posedge clk); #1 in_start = 1'b1;
    @(posedge clk); #1 in_start = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (out_valid !== 1'b1) begin
      check("present_timeout", 64'(out_valid), 64'(1));
      void'(sb.pop_back());
      chq.delete();
      return;
    end
    check("latency", 64'(cyc), 64'(3 + 2 * nb));
    check("enable_pulses", 64'(enables - e0), 64'(1 + nb));
    for (int h = 0; h < ready_wait; h++) begin
      if (h == 0) begin
        in_load_valid = 1'b1; in_load_type = 2'd1; in_load_index = 8'd0;
        in_load_value = 16'($urandom);
      end
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_value", 64'(out_value), 64'(p.v));
      check("hold_index", 64'(out_index), 64'(p.i));
      @(posedge clk); #1;
    end
    in_load_valid = 1'b0;
    in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'(0));
    for (int d = 0; d < cdelay; d++) begin
      check("commit_wait_busy", 64'(out_busy), 64'(1));
      @(posedge clk); #1;
    end
    in_commit_valid = 1'b1; in_commit_accept = acc; in_commit_value = cv;
    @(posedge clk); #1;
    in_commit_valid = 1'b0;
    if (acc) begin
      model_write(gt, gi, cv);
      m_count++;
    end
    check("idle_after_commit", 64'(out_busy), 64'(0));
    check("accept_count", 64'(out_accept_count), 64'(exp_count()));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, cyc;
    ch_t c;
    logic [1:0] gt;
    logic [7:0] gi;
    in_reset = 1'b1; in_start = 1'b0; in_ready = 1'b0;
    in_choosen_type = 2'd0; in_choosen_index = 8'd0;
    in_commit_valid = 1'b0; in_commit_accept = 1'b0; in_commit_value = 16'd0;
    in_load_valid = 1'b0; in_load_type = 2'd0; in_load_index = 8'd0; in_load_value = 16'd0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(out_busy), 64'(0));
    check("rst_enable", 64'(out_chooser_enable), 64'(0));
    check("rst_error", 64'(out_error), 64'(0));
    check("rst_type", 64'(out_type), 64'(0));
    check("rst_index", 64'(out_index), 64'(0));
    check("rst_value", 64'(out_value), 64'(0));
    check("rst_count", 64'(out_accept_count), 64'(0));
    in_reset = 1'b0;

    // Initial assignment.
    do_load(2'd0, 8'd1, 16'd1);
    do_load(2'd1, 8'd2, 16'hFFFB);
    do_load(2'd2, 8'd0, 16'd3);
    @(posedge clk); #1;
    check("load_no_valid", 64'(out_valid), 64'(0));
    check("load_busy", 64'(out_busy), 64'(0));
    check("load_no_error", 64'(seen_err), 64'(0));

    // Directed steps on int 2.
    run_step(0, 0, 2'd1, 8'd2, 4, 1'b1, 16'd7, 0);
    run_step(0, 0, 2'd1, 8'd2, 1, 1'b0, 16'd9, 1);
    run_step(0, 0, 2'd1, 8'd2, 0, 1'b0, 16'd0, 2);

    // Invalid chooser output then a valid one.
    c.t = 2'd2; c.i = 8'd5;
    chq.push_back(c);
    run_step(1, 0, 2'd0, 8'd1, 2, 1'b1, 16'hFFFE, 0);
    repeat (2) @(posedge clk);
    #1 check("retry_errors", 64'(seen_err), 64'(exp_err));

    // Load and start together: load wins, start ignored.
    @(posedge clk); #1;
    in_load_valid = 1'b1; in_load_type = 2'd2; in_load_index = 8'd1; in_load_value = 16'h1234;
    in_start = 1'b1;
    e0 = enables;
    @(posedge clk); #1;
    in_load_valid = 1'b0; in_start = 1'b0;
    model_write(2, 1, 16'h1234);
    check("load_start_busy", 64'(out_busy), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("load_start_noenable", 64'(enables - e0), 64'(0));
    check("load_start_busy2", 64'(out_busy), 64'(0));
    run_step(0, 0, 2'd2, 8'd1, 1, 1'b1, 16'h00AA, 0);

    // Invalid load targets.
    do_load(2'd3, 8'd0, 16'h4444);
    do_load(2'd1, 8'd3, 16'h5555);
    repeat (2) @(posedge clk);
    #1 check("load_errors", 64'(seen_err), 64'(exp_err));

    // Reset while presenting aborts the step.
    c.t = 2'd1; c.i = 8'd2;
    chq.push_back(c);
    @(posedge clk); #1 in_start = 1'b1;
    @(posedge clk); #1 in_start = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    in_reset = 1'b1;
    #1;
    check("mid_reset_valid", 64'(out_valid), 64'(0));
    check("mid_reset_busy", 64'(out_busy), 64'(0));
    model_clear();
    chq.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_reset = 1'b0;
    in_commit_valid = 1'b1; in_commit_accept = 1'b1; in_commit_value = 16'h0055;
    @(posedge clk); #1;
    in_commit_valid = 1'b0;
    check("post_reset_busy", 64'(out_busy), 64'(0));
    check("post_reset_count", 64'(out_accept_count), 64'(0));
    run_step(0, 0, 2'd0, 8'd1, 0, 1'b0, 16'd0, 0);
    run_step(0, 0, 2'd1, 8'd2, 0, 1'b0, 16'd0, 0);
    run_step(0, 0, 2'd2, 8'd0, 0, 1'b0, 16'd0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        in_commit_valid = 1'b1; in_commit_accept = 1'b1; in_commit_value = 16'($urandom);
        @(posedge clk); #1;
        in_commit_valid = 1'b0;
      end
      gt = 2'($urandom_range(0, 2));
      gi = (gt == 2'd0) ? 8'($urandom_range(0, NB - 1)) :
           (gt == 2'd1) ? 8'($urandom_range(0, NI - 1)) : 8'($urandom_range(0, ND - 1));
      run_step(0, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0, gt, gi,
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), 16'($urandom),
               $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #1;
    check("final_errors", 64'(seen_err), 64'(exp_err));
    check("final_count", 64'(out_accept_count), 64'(exp_count()));
    check("final_sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
